// File: rtl/frv_rvfi_retire_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frv_rvfi_retire_buffer: FIFO of retired records driving the RVFI trace.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module frv_rvfi_retire_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              rt_valid,
  output logic              rt_ready,
  input  logic [31:0]       rt_insn,
  input  logic              rt_trap,
  input  logic              rt_intr,
  input  logic [XLEN-1:0]   rt_pc_rdata,
  input  logic [XLEN-1:0]   rt_pc_wdata,
  input  logic [4:0]        rt_rs1_addr,
  input  logic [4:0]        rt_rs2_addr,
  input  logic [4:0]        rt_rd_addr,
  input  logic [XLEN-1:0]   rt_rs1_rdata,
  input  logic [XLEN-1:0]   rt_rs2_rdata,
  input  logic [XLEN-1:0]   rt_rd_wdata,
  input  logic [XLEN-1:0]   rt_mem_addr,
  input  logic [XLEN-1:0]   rt_mem_rdata,
  input  logic [XLEN-1:0]   rt_mem_wdata,
  input  logic [XLEN/8-1:0] rt_mem_rmask,
  input  logic [XLEN/8-1:0] rt_mem_wmask,
  input  logic              rvfi_stall,
  output logic              rvfi_valid,
  output logic [63:0]       rvfi_order,
  output logic [31:0]       rvfi_insn,
  output logic              rvfi_trap,
  output logic              rvfi_intr,
  output logic [XLEN-1:0]   rvfi_pc_rdata,
  output logic [XLEN-1:0]   rvfi_pc_wdata,
  output logic [4:0]        rvfi_rs1_addr,
  output logic [4:0]        rvfi_rs2_addr,
  output logic [XLEN-1:0]   rvfi_rs1_rdata,
  output logic [XLEN-1:0]   rvfi_rs2_rdata,
  output logic [4:0]        rvfi_rd_addr,
  output logic [XLEN-1:0]   rvfi_rd_wdata,
  output logic [XLEN-1:0]   rvfi_mem_addr,
  output logic [XLEN-1:0]   rvfi_mem_rdata,
  output logic [XLEN-1:0]   rvfi_mem_wdata,
  output logic [XLEN/8-1:0] rvfi_mem_rmask,
  output logic [XLEN/8-1:0] rvfi_mem_wmask,
  output logic              rvfi_halt,
  output logic [1:0]        rvfi_mode,
  output logic [1:0]        rvfi_ixl
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  typedef struct packed {
    logic [31:0]       insn;
    logic              trap;
    logic              intr;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   pc_wdata;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rd_wdata;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_rmask;
    logic [XLEN/8-1:0] mem_wmask;
  } rec_t;

  rec_t               r_mem [DEPTH];
  rec_t               w_in;
  rec_t               r_out;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic [63:0]        r_order;
  logic [63:0]        r_out_order;
  logic               r_valid;
  logic               w_push;
  logic               w_pop;

  // Ready depends only on occupancy, so a full buffer refuses a push even on a pop cycle.
  assign rt_ready = (r_count != c_full);
  assign w_push   = rt_valid && rt_ready;
  assign w_pop    = !rvfi_stall && (r_count != '0);

  // Trapped instructions and x0 destinations never report a register write.
  always_comb begin
    w_in           = '0;
    w_in.insn      = rt_insn;
    w_in.trap      = rt_trap;
    w_in.intr      = rt_intr;
    w_in.pc_rdata  = rt_pc_rdata;
    w_in.pc_wdata  = rt_pc_wdata;
    w_in.rs1_addr  = rt_rs1_addr;
    w_in.rs2_addr  = rt_rs2_addr;
    w_in.rs1_rdata = rt_rs1_rdata;
    w_in.rs2_rdata = rt_rs2_rdata;
    w_in.rd_addr   = rt_trap ? 5'd0 : rt_rd_addr;
    w_in.rd_wdata  = (rt_trap || (rt_rd_addr == 5'd0)) ? '0 : rt_rd_wdata;
    w_in.mem_addr  = rt_mem_addr;
    w_in.mem_rdata = rt_mem_rdata;
    w_in.mem_wdata = rt_mem_wdata;
    w_in.mem_rmask = rt_trap ? '0 : rt_mem_rmask;
    w_in.mem_wmask = rt_trap ? '0 : rt_mem_wmask;
  end

  always_ff @(posedge g_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_in;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_order     <= '0;
      r_out_order <= '0;
      r_valid     <= 1'b0;
      r_out       <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr      <= r_rptr + c_ptr_one;
        r_out_order <= r_order;
        r_order     <= r_order + 64'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      r_valid <= w_pop;
      r_out   <= w_pop ? r_mem[r_rptr] : '0;
    end
  end

  assign rvfi_valid     = r_valid;
  assign rvfi_order     = r_out_order;
  assign rvfi_insn      = r_out.insn;
  assign rvfi_trap      = r_out.trap;
  assign rvfi_intr      = r_out.intr;
  assign rvfi_pc_rdata  = r_out.pc_rdata;
  assign rvfi_pc_wdata  = r_out.pc_wdata;
  assign rvfi_rs1_addr  = r_out.rs1_addr;
  assign rvfi_rs2_addr  = r_out.rs2_addr;
  assign rvfi_rs1_rdata = r_out.rs1_rdata;
  assign rvfi_rs2_rdata = r_out.rs2_rdata;
  assign rvfi_rd_addr   = r_out.rd_addr;
  assign rvfi_rd_wdata  = r_out.rd_wdata;
  assign rvfi_mem_addr  = r_out.mem_addr;
  assign rvfi_mem_rdata = r_out.mem_rdata;
  assign rvfi_mem_wdata = r_out.mem_wdata;
  assign rvfi_mem_rmask = r_out.mem_rmask;
  assign rvfi_mem_wmask = r_out.mem_wmask;
  assign rvfi_halt      = 1'b0;
  assign rvfi_mode      = 2'd3;
  assign rvfi_ixl       = 2'd1;

endmodule
`default_nettype wire
